// File: rtl/cvxif_issue_buffer_if.sv
// Core-side issue, coprocessor dispatch and result channels of the CV-X-IF issue buffer.
// The buffer connects through the slave modport; the surrounding core/coprocessor uses master.
interface cvxif_issue_buffer_if #(
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned IdWidth        = 3,
    parameter int unsigned XLEN           = 64
);
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    logic                issue_valid_i;
    logic                issue_ready_o;
    logic [31:0]         issue_instr_i;
    logic [XLEN-1:0]     issue_rs1_i;
    logic [XLEN-1:0]     issue_rs2_i;
    logic [IdWidth-1:0]  issue_id_i;
    logic                flush_i;

    logic                cop_valid_o;
    logic                cop_ready_i;
    logic [31:0]         cop_instr_o;
    logic [XLEN-1:0]     cop_rs1_o;
    logic [XLEN-1:0]     cop_rs2_o;
    logic [IdWidth-1:0]  cop_id_o;

    logic                cop_result_valid_i;
    logic                cop_result_ready_o;
    logic [IdWidth-1:0]  cop_result_id_i;
    logic [XLEN-1:0]     cop_result_data_i;
    logic [4:0]          cop_result_rd_i;
    logic                cop_result_we_i;

    logic                result_valid_o;
    logic                result_ready_i;
    logic [IdWidth-1:0]  result_id_o;
    logic [XLEN-1:0]     result_data_o;
    logic [4:0]          result_rd_o;
    logic                result_we_o;

    logic [CntWidth-1:0] outstanding_o;
    logic                err_o;

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_rs1_i, issue_rs2_i, issue_id_i, flush_i,
        output issue_ready_o,
        output cop_valid_o, cop_instr_o, cop_rs1_o, cop_rs2_o, cop_id_o,
        input  cop_ready_i,
        input  cop_result_valid_i, cop_result_id_i, cop_result_data_i, cop_result_rd_i,
        input  cop_result_we_i,
        output cop_result_ready_o,
        output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
        input  result_ready_i,
        output outstanding_o, err_o
    );

    modport master (
        output issue_valid_i, issue_instr_i, issue_rs1_i, issue_rs2_i, issue_id_i, flush_i,
        input  issue_ready_o,
        input  cop_valid_o, cop_instr_o, cop_rs1_o, cop_rs2_o, cop_id_o,
        output cop_ready_i,
        output cop_result_valid_i, cop_result_id_i, cop_result_data_i, cop_result_rd_i,
        output cop_result_we_i,
        input  cop_result_ready_o,
        input  result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
        output result_ready_i,
        input  outstanding_o, err_o
    );
endinterface

// File: rtl/cvxif_issue_buffer.sv
// In-order issue FIFO between core and coprocessor with in-flight ID tracking,
// a single registered result slot back to the core and flush of undispatched entries.
module cvxif_issue_buffer #(
    parameter int unsigned Depth          = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned IdWidth        = 3,
    parameter int unsigned XLEN           = 64
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    cvxif_issue_buffer_if.slave bus
);
    localparam int unsigned AW     = $clog2(Depth);
    localparam int unsigned PW     = AW + 1;
    localparam int unsigned CW     = $clog2(MaxOutstanding + 1);
    localparam int unsigned NumIds = 2 ** IdWidth;

    logic [31:0]        mem_instr [Depth];
    logic [XLEN-1:0]    mem_rs1   [Depth];
    logic [XLEN-1:0]    mem_rs2   [Depth];
    logic [IdWidth-1:0] mem_id    [Depth];

    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PW-1:0]      queued, queued_d, slot;
    logic [CW-1:0]      dispatched_q, dispatched_d;
    logic [CW-1:0]      outstanding_q, outstanding_d;
    logic [NumIds-1:0]  bitmap_q, bitmap_d;

    logic               res_valid_q;
    logic [IdWidth-1:0] res_id_q;
    logic [XLEN-1:0]    res_data_q;
    logic [4:0]         res_rd_q;
    logic               res_we_q;
    logic               err_q;

    logic               full, empty;
    logic               issue_ready, issue_fire, issue_dup, push;
    logic               cop_valid, pop;
    logic               res_ready, res_fire, res_known, res_take;
    logic [AW-1:0]      rd_idx;

    assign rd_idx = rd_ptr_q[AW-1:0];
    assign queued = wr_ptr_q - rd_ptr_q;
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign issue_ready = !full && (outstanding_q < CW'(MaxOutstanding)) && !bus.flush_i;
    assign issue_fire  = bus.issue_valid_i && issue_ready;
    assign issue_dup   = bitmap_q[bus.issue_id_i];
    assign push        = issue_fire && !issue_dup;

    assign cop_valid = !empty && !bus.flush_i;
    assign pop       = cop_valid && bus.cop_ready_i;

    assign res_ready = !res_valid_q || bus.result_ready_i;
    assign res_fire  = bus.cop_result_valid_i && res_ready;
    assign res_known = bitmap_q[bus.cop_result_id_i];
    assign res_take  = res_fire && res_known;

    always_comb begin
        bitmap_d = bitmap_q;
        slot     = '0;
        if (bus.flush_i) begin
            for (int i = 0; i < Depth; i++) begin
                slot = rd_ptr_q + PW'(i);
                if (PW'(i) < queued) begin
                    bitmap_d[mem_id[slot[AW-1:0]]] = 1'b0;
                end
            end
        end
        if (res_take) bitmap_d[bus.cop_result_id_i] = 1'b0;
        if (push)     bitmap_d[bus.issue_id_i]      = 1'b1;
    end

    always_comb begin
        queued_d = queued;
        if (bus.flush_i) begin
            queued_d = '0;
        end else begin
            if (push) queued_d = queued_d + PW'(1);
            if (pop)  queued_d = queued_d - PW'(1);
        end
        dispatched_d = dispatched_q;
        if (pop) dispatched_d = dispatched_d + CW'(1);
        // A result naming an ID that is still queued must not underflow the count.
        if (res_take && dispatched_d != '0) dispatched_d = dispatched_d - CW'(1);
        outstanding_d = CW'(queued_d) + dispatched_d;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_instr[wr_ptr_q[AW-1:0]] <= bus.issue_instr_i;
            mem_rs1[wr_ptr_q[AW-1:0]]   <= bus.issue_rs1_i;
            mem_rs2[wr_ptr_q[AW-1:0]]   <= bus.issue_rs2_i;
            mem_id[wr_ptr_q[AW-1:0]]    <= bus.issue_id_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            dispatched_q  <= '0;
            outstanding_q <= '0;
            bitmap_q      <= '0;
            res_valid_q   <= 1'b0;
            res_id_q      <= '0;
            res_data_q    <= '0;
            res_rd_q      <= '0;
            res_we_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            if (bus.flush_i) begin
                rd_ptr_q <= wr_ptr_q;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            dispatched_q  <= dispatched_d;
            outstanding_q <= outstanding_d;
            bitmap_q      <= bitmap_d;
            if (res_take) begin
                res_valid_q <= 1'b1;
                res_id_q    <= bus.cop_result_id_i;
                res_data_q  <= bus.cop_result_data_i;
                res_rd_q    <= bus.cop_result_rd_i;
                res_we_q    <= bus.cop_result_we_i;
            end else if (bus.result_ready_i) begin
                res_valid_q <= 1'b0;
            end
            err_q <= (issue_fire && issue_dup) || (res_fire && !res_known);
        end
    end

    assign bus.issue_ready_o      = issue_ready;
    assign bus.cop_valid_o        = cop_valid;
    // Head payload is masked while empty so stale entries never show after reset or flush.
    assign bus.cop_instr_o        = empty ? '0 : mem_instr[rd_idx];
    assign bus.cop_rs1_o          = empty ? '0 : mem_rs1[rd_idx];
    assign bus.cop_rs2_o          = empty ? '0 : mem_rs2[rd_idx];
    assign bus.cop_id_o           = empty ? '0 : mem_id[rd_idx];
    assign bus.cop_result_ready_o = res_ready;
    assign bus.result_valid_o     = res_valid_q;
    assign bus.result_id_o        = res_id_q;
    assign bus.result_data_o      = res_data_q;
    assign bus.result_rd_o        = res_rd_q;
    assign bus.result_we_o        = res_we_q;
    assign bus.outstanding_o      = outstanding_q;
    assign bus.err_o              = err_q;
endmodule

// File: tb/tb_cvxif_issue_buffer.sv
// Self-checking bench for cvxif_issue_buffer: vector table plus directed corner sequences,
// with dispatch and result scoreboards checked by a negedge monitor.
module tb_cvxif_issue_buffer;
    localparam int unsigned Depth  = 4;
    localparam int unsigned MaxOut = 4;
    localparam int unsigned IdW    = 3;
    localparam int unsigned XLEN   = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cvxif_issue_buffer_if #(.MaxOutstanding(MaxOut), .IdWidth(IdW), .XLEN(XLEN)) bus();

    cvxif_issue_buffer #(.Depth(Depth), .MaxOutstanding(MaxOut), .IdWidth(IdW), .XLEN(XLEN)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [2:0]  id;
    } disp_t;

    typedef struct {
        logic [2:0]  id;
        logic [63:0] data;
        logic [4:0]  rd;
        logic        we;
    } res_t;

    typedef struct {
        logic       iv;
        logic [2:0] id;
        logic       cr;
        logic       e_ir;
        logic       e_cv;
        logic [2:0] e_cid;
        logic [2:0] e_out;
    } vec_t;

    disp_t exp_disp[$];
    res_t  exp_res[$];
    disp_t mon_d;
    res_t  mon_r;
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.issue_valid_i      = 1'b0;
        bus.issue_instr_i      = '0;
        bus.issue_rs1_i        = '0;
        bus.issue_rs2_i        = '0;
        bus.issue_id_i         = '0;
        bus.flush_i            = 1'b0;
        bus.cop_ready_i        = 1'b0;
        bus.cop_result_valid_i = 1'b0;
        bus.cop_result_id_i    = '0;
        bus.cop_result_data_i  = '0;
        bus.cop_result_rd_i    = '0;
        bus.cop_result_we_i    = 1'b0;
        bus.result_ready_i     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        exp_disp.delete();
        exp_res.delete();
        rst_n = 1'b1;
    endtask

    function automatic disp_t mk(input logic [2:0] id);
        disp_t d;
        d.instr = 32'h0000_000B + {29'd0, id};
        d.rs1   = {32'hA5A5_0000, 29'd0, id};
        d.rs2   = {$urandom, $urandom};
        d.id    = id;
        return d;
    endfunction

    task automatic issue(input logic [2:0] id, input bit accept);
        disp_t d;
        d = mk(id);
        bus.issue_valid_i = 1'b1;
        bus.issue_instr_i = d.instr;
        bus.issue_rs1_i   = d.rs1;
        bus.issue_rs2_i   = d.rs2;
        bus.issue_id_i    = d.id;
        if (accept) exp_disp.push_back(d);
    endtask

    task automatic send_result(input logic [2:0] id, input logic [63:0] data,
                               input logic [4:0] rd, input logic we, input bit expect_out);
        res_t r;
        bus.cop_result_valid_i = 1'b1;
        bus.cop_result_id_i    = id;
        bus.cop_result_data_i  = data;
        bus.cop_result_rd_i    = rd;
        bus.cop_result_we_i    = we;
        r.id = id; r.data = data; r.rd = rd; r.we = we;
        if (expect_out) exp_res.push_back(r);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.cop_valid_o && bus.cop_ready_i) begin
            if (exp_disp.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_dispatch: got id %0d, required no dispatch", bus.cop_id_o);
            end else begin
                mon_d = exp_disp.pop_front();
                chk("disp_id",    bus.cop_id_o,    mon_d.id);
                chk("disp_instr", bus.cop_instr_o, mon_d.instr);
                chk("disp_rs1",   bus.cop_rs1_o,   mon_d.rs1);
                chk("disp_rs2",   bus.cop_rs2_o,   mon_d.rs2);
            end
        end
        if (rst_n && bus.result_valid_o && bus.result_ready_i) begin
            if (exp_res.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got id %0d, required no result", bus.result_id_o);
            end else begin
                mon_r = exp_res.pop_front();
                chk("res_id",   bus.result_id_o,   mon_r.id);
                chk("res_data", bus.result_data_o, mon_r.data);
                chk("res_rd",   bus.result_rd_o,   mon_r.rd);
                chk("res_we",   bus.result_we_o,   mon_r.we);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    vec_t vt[7];

    initial begin
        // iv id cr | ready cvalid cop_id outstanding (outputs seen before the row's clock edge)
        vt[0] = '{1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0};
        vt[1] = '{1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 3'd0, 3'd1};
        vt[2] = '{1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 3'd1, 3'd2};
        vt[3] = '{1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 3'd2, 3'd3};
        vt[4] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 3'd4};
        vt[5] = '{1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 3'd0, 3'd4};
        vt[6] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd4};

        idle_inputs();
        do_reset();
        settle();
        chk("rst_out",    bus.outstanding_o,  3'd0);
        chk("rst_cvalid", bus.cop_valid_o,    1'b0);
        chk("rst_rvalid", bus.result_valid_o, 1'b0);
        chk("rst_err",    bus.err_o,          1'b0);
        chk("rst_ready",  bus.issue_ready_o,  1'b1);

        // In-order issue/dispatch until the outstanding limit is reached
        for (int i = 0; i < 7; i++) begin
            bus.cop_ready_i = vt[i].cr;
            if (vt[i].iv) issue(vt[i].id, vt[i].e_ir);
            else          bus.issue_valid_i = 1'b0;
            settle();
            chk($sformatf("vec%0d_ready", i),  bus.issue_ready_o, vt[i].e_ir);
            chk($sformatf("vec%0d_cvalid", i), bus.cop_valid_o,   vt[i].e_cv);
            chk($sformatf("vec%0d_copid", i),  bus.cop_id_o,      vt[i].e_cid);
            chk($sformatf("vec%0d_out", i),    bus.outstanding_o, vt[i].e_out);
            tick();
        end
        bus.issue_valid_i = 1'b0;
        settle();
        chk("vec_drained", exp_disp.size(), 0);

        // Backpressure: fill the FIFO, head stays stable, then drain back-to-back
        do_reset();
        for (int n = 0; n < 4; n++) begin
            issue(3'(n), 1'b1);
            settle();
            chk("bp_issue_ready", bus.issue_ready_o, 1'b1);
            tick();
        end
        bus.issue_valid_i = 1'b0;
        settle();
        chk("bp_full_ready", bus.issue_ready_o, 1'b0);
        chk("bp_out",        bus.outstanding_o, 3'd4);
        for (int k = 0; k < 3; k++) begin
            chk("bp_cvalid",     bus.cop_valid_o, 1'b1);
            chk("bp_head_id",    bus.cop_id_o,    3'd0);
            chk("bp_head_instr", bus.cop_instr_o, 32'h0000_000B);
            tick();
        end
        bus.cop_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        settle();
        chk("bp_empty_cvalid", bus.cop_valid_o,  1'b0);
        chk("bp_drained",      exp_disp.size(),  0);
        chk("bp_out_after",    bus.outstanding_o, 3'd4);

        // Flush drops queued ID 2 but keeps dispatched ID 1 tracked
        do_reset();
        issue(3'd1, 1'b1);
        tick();
        issue(3'd2, 1'b1);
        tick();
        bus.issue_valid_i = 1'b0;
        bus.cop_ready_i   = 1'b1;
        settle();
        chk("fl_head", bus.cop_id_o, 3'd1);
        tick();
        bus.cop_ready_i = 1'b0;
        bus.flush_i     = 1'b1;
        issue(3'd6, 1'b0);
        exp_disp.delete();
        settle();
        chk("fl_ready",  bus.issue_ready_o, 1'b0);
        chk("fl_cvalid", bus.cop_valid_o,   1'b0);
        tick();
        bus.flush_i       = 1'b0;
        bus.issue_valid_i = 1'b0;
        settle();
        chk("fl_empty", bus.cop_valid_o,   1'b0);
        chk("fl_out",   bus.outstanding_o, 3'd1);
        issue(3'd2, 1'b1);
        settle();
        chk("fl_reissue_ready", bus.issue_ready_o, 1'b1);
        tick();
        bus.issue_valid_i = 1'b0;
        settle();
        chk("fl_reissue_err", bus.err_o,         1'b0);
        chk("fl_reissue_out", bus.outstanding_o, 3'd2);
        issue(3'd1, 1'b0);
        tick();
        bus.issue_valid_i = 1'b0;
        settle();
        chk("fl_dup_disp_err", bus.err_o,         1'b1);
        chk("fl_dup_disp_out", bus.outstanding_o, 3'd2);
        bus.cop_ready_i = 1'b1;
        tick();
        tick();
        chk("fl_drained", exp_disp.size(), 0);

        // Result held under core backpressure
        do_reset();
        bus.cop_ready_i = 1'b1;
        issue(3'd5, 1'b1);
        tick();
        bus.issue_valid_i = 1'b0;
        tick();
        bus.cop_ready_i = 1'b0;
        settle();
        chk("res_pre_out", bus.outstanding_o, 3'd1);
        send_result(3'd5, 64'hDEAD, 5'd7, 1'b1, 1'b1);
        settle();
        chk("res_accept_ready", bus.cop_result_ready_o, 1'b1);
        tick();
        bus.cop_result_valid_i = 1'b0;
        settle();
        chk("res_post_out", bus.outstanding_o, 3'd0);
        for (int k = 0; k < 3; k++) begin
            chk("res_hold_valid", bus.result_valid_o,     1'b1);
            chk("res_hold_ready", bus.cop_result_ready_o, 1'b0);
            chk("res_hold_data",  bus.result_data_o,      64'hDEAD);
            chk("res_hold_rd",    bus.result_rd_o,        5'd7);
            chk("res_hold_id",    bus.result_id_o,        3'd5);
            tick();
        end
        bus.result_ready_i = 1'b1;
        tick();
        settle();
        chk("res_cleared", bus.result_valid_o, 1'b0);
        chk("res_drained", exp_res.size(),     0);

        // Unknown result ID and duplicate issue ID
        do_reset();
        bus.result_ready_i = 1'b1;
        send_result(3'd6, 64'h1234, 5'd2, 1'b1, 1'b0);
        settle();
        chk("unk_ready", bus.cop_result_ready_o, 1'b1);
        tick();
        bus.cop_result_valid_i = 1'b0;
        settle();
        chk("unk_err",    bus.err_o,          1'b1);
        chk("unk_rvalid", bus.result_valid_o, 1'b0);
        tick();
        chk("unk_err_end", bus.err_o,         1'b0);
        chk("unk_out",     bus.outstanding_o, 3'd0);
        issue(3'd3, 1'b1);
        tick();
        issue(3'd3, 1'b0);
        settle();
        chk("dup_ready", bus.issue_ready_o, 1'b1);
        tick();
        bus.issue_valid_i = 1'b0;
        settle();
        chk("dup_err", bus.err_o,         1'b1);
        chk("dup_out", bus.outstanding_o, 3'd1);
        tick();
        chk("dup_err_end", bus.err_o, 1'b0);
        bus.cop_ready_i = 1'b1;
        tick();
        tick();
        chk("dup_cvalid", bus.cop_valid_o, 1'b0);
        chk("dup_drained", exp_disp.size(), 0);

        // Reset with queued entries and a pending result
        do_reset();
        bus.cop_ready_i = 1'b1;
        issue(3'd0, 1'b1);
        tick();
        bus.issue_valid_i = 1'b0;
        tick();
        bus.cop_ready_i = 1'b0;
        issue(3'd1, 1'b1);
        tick();
        issue(3'd2, 1'b1);
        tick();
        bus.issue_valid_i = 1'b0;
        send_result(3'd0, 64'h55, 5'd3, 1'b1, 1'b0);
        tick();
        bus.cop_result_valid_i = 1'b0;
        settle();
        chk("mid_rvalid", bus.result_valid_o, 1'b1);
        chk("mid_out",    bus.outstanding_o,  3'd2);
        rst_n = 1'b0;
        tick();
        settle();
        chk("mrst_cvalid", bus.cop_valid_o,    1'b0);
        chk("mrst_copid",  bus.cop_id_o,       3'd0);
        chk("mrst_instr",  bus.cop_instr_o,    32'd0);
        chk("mrst_rs1",    bus.cop_rs1_o,      64'd0);
        chk("mrst_rvalid", bus.result_valid_o, 1'b0);
        chk("mrst_rdata",  bus.result_data_o,  64'd0);
        chk("mrst_rid",    bus.result_id_o,    3'd0);
        chk("mrst_err",    bus.err_o,          1'b0);
        chk("mrst_out",    bus.outstanding_o,  3'd0);
        exp_disp.delete();
        exp_res.delete();
        rst_n = 1'b1;
        tick();
        chk("mrst_ready", bus.issue_ready_o, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
